// File: rtl/piezo_decode.sv
// Piezo tone receive decoder: measures audio half-periods, locks a status code after
// two matching intervals, drops to silent on timeout, and monitors pair complementarity.
module piezo_decode #(
  parameter bit          FAST_SIM = 1'b0,
  parameter int unsigned TOL      = 1,
  parameter int unsigned DIFF_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       audio,
  input  logic       audio_n,
  output logic [2:0] tone_code,
  output logic       moving,
  output logic       batt_low,
  output logic       ovr_spd,
  output logic       code_vld,
  output logic       len_err,
  output logic       diff_err
);

  localparam int unsigned CW = 28;
  localparam int unsigned LW = CW + 1;
  localparam int unsigned B  = FAST_SIM ? 2 : 23;
  localparam int unsigned DW = $clog2(DIFF_MAX + 2);
  localparam logic [CW-1:0] TMO  = CW'(2 ** (B + 4));
  localparam logic [DW-1:0] DMAX = DW'(DIFF_MAX);

  typedef enum logic [1:0] {
    ST_SILENT,
    ST_SEEK,
    ST_PEND,
    ST_LOCKED
  } state_e;

  state_e        state_q;
  logic [2:0]    cand_q;
  logic          a_q;
  logic          a_q2;
  logic [CW-1:0] hp_cnt_q;
  logic [CW-1:0] hp_cnt_d;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          edge_c;
  logic [LW-1:0] len_c;
  logic [2:0]    cls_c;

  // Class k (nominal 2^(B+k)) maps to code 4-k; 0 means no class matched.
  function automatic logic [2:0] classify(input logic [LW-1:0] len);
    logic [2:0]    code;
    logic [LW-1:0] nom;
    code = 3'd0;
    for (int k = 0; k < 4; k++) begin
      nom = LW'(2 ** (B + k));
      if ((len + LW'(TOL) >= nom) && (len <= nom + LW'(TOL))) code = 3'(4 - k);
    end
    return code;
  endfunction

  // Status flags {moving, batt_low, ovr_spd} for a tone code.
  function automatic logic [2:0] flags(input logic [2:0] code);
    return {code == 3'd1, (code == 3'd2) || (code == 3'd4), (code == 3'd3) || (code == 3'd4)};
  endfunction

  always_comb begin
    edge_c   = a_q ^ a_q2;
    len_c    = LW'(hp_cnt_q) + LW'(1);
    cls_c    = (&hp_cnt_q) ? 3'd0 : classify(len_c);
    hp_cnt_d = hp_cnt_q;
    if (edge_c) begin
      hp_cnt_d = '0;
    end else if (!(&hp_cnt_q)) begin
      hp_cnt_d = hp_cnt_q + CW'(1);
    end
    dcnt_d = '0;
    if (audio == audio_n) begin
      dcnt_d = (dcnt_q >= DMAX) ? dcnt_q : dcnt_q + DW'(1);
    end
  end

  // Edge history, half-period counter and complement monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 1'b0;
      a_q2     <= 1'b0;
      hp_cnt_q <= '0;
      dcnt_q   <= '0;
      diff_err <= 1'b0;
    end else begin
      a_q      <= audio;
      a_q2     <= a_q;
      hp_cnt_q <= hp_cnt_d;
      dcnt_q   <= dcnt_d;
      diff_err <= (dcnt_d >= DMAX);
    end
  end

  // Lock FSM; an edge takes priority over the silence timeout on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SILENT;
      cand_q    <= 3'd0;
      tone_code <= 3'd0;
      moving    <= 1'b0;
      batt_low  <= 1'b0;
      ovr_spd   <= 1'b0;
      code_vld  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      code_vld <= 1'b0;
      len_err  <= 1'b0;
      if (edge_c) begin
        case (state_q)
          ST_SILENT: state_q <= ST_SEEK;
          ST_SEEK: begin
            if (cls_c != 3'd0) begin
              state_q <= ST_PEND;
              cand_q  <= cls_c;
            end else begin
              len_err <= 1'b1;
            end
          end
          ST_PEND, ST_LOCKED: begin
            if (cls_c == 3'd0) begin
              len_err <= 1'b1;
              state_q <= ST_SEEK;
            end else if (cls_c == cand_q) begin
              state_q                       <= ST_LOCKED;
              tone_code                     <= cls_c;
              {moving, batt_low, ovr_spd}   <= flags(cls_c);
              code_vld                      <= (cls_c != tone_code);
            end else begin
              state_q <= ST_PEND;
              cand_q  <= cls_c;
            end
          end
          default: state_q <= ST_SILENT;
        endcase
      end else if ((state_q != ST_SILENT) && (hp_cnt_q >= TMO)) begin
        state_q                     <= ST_SILENT;
        tone_code                   <= 3'd0;
        {moving, batt_low, ovr_spd} <= 3'b000;
        code_vld                    <= (tone_code != 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_piezo_decode.sv
// Bench for piezo_decode (FAST_SIM=1): directed tone scenarios plus random half-periods,
// checked every cycle against an interval-level model of the tone rules.
module tb_piezo_decode;

  localparam int TOL      = 1;
  localparam int DIFF_MAX = 4;
  localparam int LONGEST  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       audio = 1'b0;
  logic       audio_n = 1'b1;
  logic [2:0] tone_code;
  logic       moving, batt_low, ovr_spd, code_vld, len_err, diff_err;

  always #5 clk = ~clk;

  piezo_decode #(.FAST_SIM(1'b1), .TOL(TOL), .DIFF_MAX(DIFF_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .audio    (audio),
    .audio_n  (audio_n),
    .tone_code(tone_code),
    .moving   (moving),
    .batt_low (batt_low),
    .ovr_spd  (ovr_spd),
    .code_vld (code_vld),
    .len_err  (len_err),
    .diff_err (diff_err)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int n_vld = 0;
  int n_len = 0;

  bit         lit_req = 1'b0;
  string      lit_name;
  logic [8:0] lit_out;
  int         lit_dv, lit_dl, lit_vbase, lit_lbase;

  // Model: interval-level tone rules, timestamps in clock cycles.
  bit m_s1, m_s2, m_active, m_vld, m_len, m_diff;
  int m_cand, m_tone, m_cyc, m_last, m_dcnt;

  function automatic int tone_class(input int len);
    int c;
    int nom;
    c = 0;
    for (int k = 0; k < 4; k++) begin
      nom = 4 << k;
      if (len >= nom - TOL && len <= nom + TOL) c = 4 - k;
    end
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int now, cls, cand_n, tone_n, d_n;
    bit act_n, vld_n, len_n;
    if (!rst_n) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_active <= 1'b0; m_vld <= 1'b0; m_len <= 1'b0;
      m_diff <= 1'b0; m_cand <= 0; m_tone <= 0; m_cyc <= 0; m_last <= 0; m_dcnt <= 0;
    end else begin
      now = m_cyc + 1;
      cand_n = m_cand; tone_n = m_tone; act_n = m_active; vld_n = 1'b0; len_n = 1'b0;
      if (m_s1 != m_s2) begin
        if (!m_active) begin
          act_n = 1'b1;
          cand_n = 0;
        end else begin
          cls = tone_class(now - m_last);
          if (cls == 0) begin
            len_n = 1'b1;
            cand_n = 0;
          end else if (cls == m_cand) begin
            vld_n = (cls != m_tone);
            tone_n = cls;
          end else begin
            cand_n = cls;
          end
        end
        m_last <= now;
      end else if (m_active && (now - m_last > 2 * LONGEST)) begin
        act_n = 1'b0; cand_n = 0; vld_n = (m_tone != 0); tone_n = 0;
      end
      d_n = (audio == audio_n) ? m_dcnt + 1 : 0;
      m_active <= act_n; m_cand <= cand_n; m_tone <= tone_n; m_vld <= vld_n; m_len <= len_n;
      m_dcnt <= d_n; m_diff <= (d_n >= DIFF_MAX);
      m_s2 <= m_s1; m_s1 <= audio; m_cyc <= now;
    end
  end

  // Single checker: model compare every cycle plus any pending literal expectation.
  always @(negedge clk) begin : cmp
    logic [8:0] got, exp;
    if (chk_en) begin
      n_vld += int'(code_vld);
      n_len += int'(len_err);
      got = {tone_code, moving, batt_low, ovr_spd, code_vld, len_err, diff_err};
      exp = {3'(m_tone), m_tone == 1, (m_tone == 2) || (m_tone == 4),
             (m_tone == 3) || (m_tone == 4), m_vld, m_len, m_diff};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL model t=%0t outputs got %b expected %b (tone,mv,bl,os,vld,len,diff)",
                 $time, got, exp);
      end
      if (lit_req) begin
        vectors++;
        if (got !== lit_out) begin
          miscompares++;
          $display("FAIL %s outputs got %b expected %b", lit_name, got, lit_out);
        end
        if (lit_dv >= 0) begin
          vectors++;
          if (n_vld - lit_vbase != lit_dv) begin
            miscompares++;
            $display("FAIL %s code_vld pulses got %0d expected %0d", lit_name, n_vld - lit_vbase, lit_dv);
          end
        end
        if (lit_dl >= 0) begin
          vectors++;
          if (n_len - lit_lbase != lit_dl) begin
            miscompares++;
            $display("FAIL %s len_err pulses got %0d expected %0d", lit_name, n_len - lit_lbase, lit_dl);
          end
        end
      end
    end
  end

  task automatic mark();
    lit_vbase = n_vld;
    lit_lbase = n_len;
  endtask

  task automatic expect_out(input string name, input logic [8:0] out, input int dv, input int dl);
    lit_name = name; lit_out = out; lit_dv = dv; lit_dl = dl;
    lit_req = 1'b1;
    @(negedge clk);
    #1 lit_req = 1'b0;
  endtask

  task automatic half(input int hp, input bit tie);
    audio = ~audio;
    audio_n = tie ? audio : ~audio;
    repeat (hp) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int r, hp, reps;
    @(posedge clk);
    #2 chk_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    expect_out("reset", 9'b000_000_000, -1, -1);

    mark();
    repeat (4) half(32, 1'b0);
    expect_out("lock_32", 9'b001_100_000, 1, 0);

    mark();
    repeat (6) half(4, 1'b0);
    expect_out("switch_4", 9'b100_011_000, 1, 0);

    mark();
    half(5, 1'b0); half(3, 1'b0); half(5, 1'b0); half(3, 1'b0);
    expect_out("tol_5_3", 9'b100_011_000, 0, 0);

    mark();
    idle(80);
    expect_out("timeout", 9'b000_000_000, 1, -1);

    mark();
    repeat (4) half(16, 1'b0);
    expect_out("lock_16", 9'b010_010_000, 1, 0);
    mark();
    half(12, 1'b0);
    half(16, 1'b0);
    expect_out("bad_12", 9'b010_010_000, 0, 1);
    half(16, 1'b0);
    half(16, 1'b0);
    expect_out("relock_16", 9'b010_010_000, 0, 1);

    audio_n = audio;
    idle(6);
    expect_out("diff_rise", 9'b010_010_001, -1, -1);
    repeat (4) half(8, 1'b1);
    expect_out("tied_lock_8", 9'b011_001_001, -1, -1);
    audio_n = ~audio;
    idle(2);
    expect_out("diff_clear", 9'b011_001_000, -1, -1);

    repeat (4) half(8, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    audio = 1'b0;
    audio_n = 1'b1;
    expect_out("async_reset", 9'b000_000_000, -1, -1);
    idle(3);
    rst_n = 1'b1;
    mark();
    half(8, 1'b0); half(8, 1'b0);
    expect_out("two_edges", 9'b000_000_000, 0, -1);
    half(8, 1'b0);
    expect_out("third_edge", 9'b011_001_000, 1, -1);

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      reps = $urandom_range(1, 4);
      if (r < 8) hp = (4 << $urandom_range(0, 3)) + $urandom_range(0, 2) - 1;
      else if (r == 8) hp = $urandom_range(1, 40);
      else hp = $urandom_range(60, 70);
      for (int j = 0; j < reps; j++) half(hp, $urandom_range(0, 7) == 0);
    end
    audio_n = ~audio;
    idle(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
